// File: rtl/intersection_phase_scheduler.sv
// Two-way intersection phase scheduler: NS/EW greens with yellow and all-red
// clearance, demand-actuated green extension and rest-on-green.
// Optional pedestrian walk support is compiled in with `define PED_WALK_EN.
// Without it the ped_* inputs are ignored and walk_* are tied low.
module intersection_phase_scheduler #(
   parameter int unsigned GREEN_MIN = 5,
   parameter int unsigned GREEN_MAX = 12,
   parameter int unsigned YELLOW_T  = 2,
   parameter int unsigned ALLRED_T  = 1,
   parameter int unsigned WALK_T    = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       car_ns,
   input  logic       car_ew,
   input  logic       ped_ns,
   input  logic       ped_ew,
   output logic [2:0] NS_light,
   output logic [2:0] EW_light,
   output logic       walk_ns,
   output logic       walk_ew,
   output logic [2:0] phase
);

   // Elaboration-time parameter sanity checks.
   if (GREEN_MIN < 1 || GREEN_MIN > 31 || GREEN_MAX < 1 || GREEN_MAX > 31 ||
       YELLOW_T < 1 || YELLOW_T > 31 || ALLRED_T < 1 || ALLRED_T > 31 ||
       WALK_T < 1 || WALK_T > 31) begin : g_bad_range
      $error("intersection_phase_scheduler: durations must be 1..31");
   end
   if (WALK_T > GREEN_MIN || GREEN_MIN > GREEN_MAX) begin : g_bad_order
      $error("intersection_phase_scheduler: need WALK_T <= GREEN_MIN <= GREEN_MAX");
   end

   localparam logic [2:0] LightRed    = 3'b100;
   localparam logic [2:0] LightYellow = 3'b010;
   localparam logic [2:0] LightGreen  = 3'b001;

   localparam logic [4:0] GreenMin   = 5'(GREEN_MIN);
   localparam logic [4:0] GreenMax   = 5'(GREEN_MAX);
   localparam logic [4:0] YellowLast = 5'(YELLOW_T - 1);
   localparam logic [4:0] AllRedLast = 5'(ALLRED_T - 1);

   // Encodings double as the externally visible phase code.
   typedef enum logic [2:0] {
      StArNs = 3'd0,
      StNsG  = 3'd1,
      StNsY  = 3'd2,
      StArEw = 3'd3,
      StEwG  = 3'd4,
      StEwY  = 3'd5
   } state_e;

   state_e     state_q, state_d;
   logic [4:0] elapsed_q, elapsed_d;
   logic [4:0] elapsed_inc;
   logic       released_q;
   logic       tick_ok;
   logic       pend_ns_q, pend_ns_d;
   logic       pend_ew_q, pend_ew_d;
   logic       set_ns, set_ew;
   logic       enter_ns_g, enter_ew_g;
   logic [2:0] ns_light_c, ew_light_c;

   // The first edge after reset release ignores tick.
   assign tick_ok = tick & released_q;

   // Saturating increment of the elapsed-tick counter.
   assign elapsed_inc = (elapsed_q == 5'd31) ? 5'd31 : elapsed_q + 5'd1;

   // Next-state decode: timed exits and the demand-driven green exit.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StArNs: if (tick_ok && elapsed_q == AllRedLast) state_d = StNsG;
         StNsG: begin
            if (tick_ok && pend_ew_q &&
                ((elapsed_inc >= GreenMin && !car_ns) || elapsed_inc >= GreenMax)) begin
               state_d = StNsY;
            end
         end
         StNsY:  if (tick_ok && elapsed_q == YellowLast) state_d = StArEw;
         StArEw: if (tick_ok && elapsed_q == AllRedLast) state_d = StEwG;
         StEwG: begin
            if (tick_ok && pend_ns_q &&
                ((elapsed_inc >= GreenMin && !car_ew) || elapsed_inc >= GreenMax)) begin
               state_d = StEwY;
            end
         end
         StEwY:  if (tick_ok && elapsed_q == YellowLast) state_d = StArNs;
         default: state_d = StArNs;
      endcase
   end

   // Elapsed counter restarts on every state entry, otherwise counts ticks.
   always_comb begin
      elapsed_d = elapsed_q;
      if (state_d != state_q) begin
         elapsed_d = 5'd0;
      end else if (tick_ok) begin
         elapsed_d = elapsed_inc;
      end
   end

   assign enter_ns_g = (state_d == StNsG) && (state_q != StNsG);
   assign enter_ew_g = (state_d == StEwG) && (state_q != StEwG);

`ifdef PED_WALK_EN
   assign set_ns = car_ns | ped_ns;
   assign set_ew = car_ew | ped_ew;
`else
   logic unused_ped;
   assign unused_ped = ped_ns ^ ped_ew;
   assign set_ns     = car_ns;
   assign set_ew     = car_ew;
`endif

   // Request latches clear on entry to their own green; a same-edge set wins.
   always_comb begin
      pend_ns_d = set_ns | (pend_ns_q & ~enter_ns_g);
      pend_ew_d = set_ew | (pend_ew_q & ~enter_ew_g);
   end

   // FSM, counter and request-latch state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StArNs;
         elapsed_q  <= 5'd0;
         released_q <= 1'b0;
         pend_ns_q  <= 1'b0;
         pend_ew_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         elapsed_q  <= elapsed_d;
         released_q <= 1'b1;
         pend_ns_q  <= pend_ns_d;
         pend_ew_q  <= pend_ew_d;
      end
   end

   // Light decode from the current state; only one direction may leave red.
   always_comb begin
      ns_light_c = LightRed;
      ew_light_c = LightRed;
      case (state_q)
         StNsG:   ns_light_c = LightGreen;
         StNsY:   ns_light_c = LightYellow;
         StEwG:   ew_light_c = LightGreen;
         StEwY:   ew_light_c = LightYellow;
         default: ;
      endcase
   end

   // Registered lights and phase, one clock behind the state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         NS_light <= LightRed;
         EW_light <= LightRed;
         phase    <= 3'd0;
      end else begin
         NS_light <= ns_light_c;
         EW_light <= ew_light_c;
         phase    <= state_q;
      end
   end

`ifdef PED_WALK_EN
   logic pwalk_ns_q, pwalk_ns_d;
   logic pwalk_ew_q, pwalk_ew_d;
   logic walk_en_ns_q, walk_en_ns_d;
   logic walk_en_ew_q, walk_en_ew_d;
   logic walk_ns_c, walk_ew_c;

   // Walk requests latch like vehicle requests; the grant is sampled at green entry.
   always_comb begin
      pwalk_ns_d   = ped_ns | (pwalk_ns_q & ~enter_ns_g);
      pwalk_ew_d   = ped_ew | (pwalk_ew_q & ~enter_ew_g);
      walk_en_ns_d = enter_ns_g ? pwalk_ns_q : walk_en_ns_q;
      walk_en_ew_d = enter_ew_g ? pwalk_ew_q : walk_en_ew_q;
      walk_ns_c    = (state_q == StNsG) && walk_en_ns_q && (elapsed_q < 5'(WALK_T));
      walk_ew_c    = (state_q == StEwG) && walk_en_ew_q && (elapsed_q < 5'(WALK_T));
   end

   // Pedestrian latches and registered walk outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pwalk_ns_q   <= 1'b0;
         pwalk_ew_q   <= 1'b0;
         walk_en_ns_q <= 1'b0;
         walk_en_ew_q <= 1'b0;
         walk_ns      <= 1'b0;
         walk_ew      <= 1'b0;
      end else begin
         pwalk_ns_q   <= pwalk_ns_d;
         pwalk_ew_q   <= pwalk_ew_d;
         walk_en_ns_q <= walk_en_ns_d;
         walk_en_ew_q <= walk_en_ew_d;
         walk_ns      <= walk_ns_c;
         walk_ew      <= walk_ew_c;
      end
   end
`else
   assign walk_ns = 1'b0;
   assign walk_ew = 1'b0;
`endif

   // Conflicting greens/yellows must never be displayed.
   a_one_dir_non_red : assert property (@(posedge clk) disable iff (!rst)
      (NS_light == LightRed) || (EW_light == LightRed));

   a_walk_exclusive : assert property (@(posedge clk) disable iff (!rst)
      !(walk_ns && walk_ew));

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Scoreboard bench for intersection_phase_scheduler (default parameters).
// Walk scenarios are exercised when PED_WALK_EN is defined; otherwise the
// bench checks that pedestrian inputs are ignored.
module tb_intersection_phase_scheduler;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tick = 1'b0;
   logic       car_ns = 1'b0;
   logic       car_ew = 1'b0;
   logic       ped_ns = 1'b0;
   logic       ped_ew = 1'b0;
   logic [2:0] NS_light;
   logic [2:0] EW_light;
   logic       walk_ns;
   logic       walk_ew;
   logic [2:0] phase;

   int n_run  = 0;
   int n_fail = 0;

   // Expected {phase, NS_light, EW_light, walk_ns, walk_ew}.
   logic [10:0] sb[$];
   logic [10:0] exp_v;
   logic [10:0] obs;
   assign obs = {phase, NS_light, EW_light, walk_ns, walk_ew};

   intersection_phase_scheduler dut (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .car_ns   (car_ns),
      .car_ew   (car_ew),
      .ped_ns   (ped_ns),
      .ped_ew   (ped_ew),
      .NS_light (NS_light),
      .EW_light (EW_light),
      .walk_ns  (walk_ns),
      .walk_ew  (walk_ew),
      .phase    (phase)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, run=%0d failed=%0d", n_run, n_fail);
      $fatal(1, "watchdog");
   end

   // Expected outputs for a phase code, lights taken from the state table.
   function automatic logic [10:0] exp_of(input int ph, input logic wn, input logic we);
      logic [2:0] ns, ew;
      ns = 3'b100;
      ew = 3'b100;
      case (ph)
         1: ns = 3'b001;
         2: ns = 3'b010;
         4: ew = 3'b001;
         5: ew = 3'b010;
         default: ;
      endcase
      return {3'(ph), ns, ew, wn, we};
   endfunction

   function automatic string fmt(input logic [10:0] v);
      return $sformatf("phase=%0d ns=%b ew=%b walk_ns=%b walk_ew=%b",
                       v[10:8], v[7:5], v[4:2], v[1], v[0]);
   endfunction

   // Optional request pulse, then one tick cycle and two settle cycles.
   // act: 1 car_ew pulse, 2 car_ns pulse, 3 EW request on the tick edge, 4 ped_ew pulse.
   task automatic do_step(input int act);
      case (act)
         1: begin car_ew = 1'b1; @(negedge clk); car_ew = 1'b0; end
         2: begin car_ns = 1'b1; @(negedge clk); car_ns = 1'b0; end
         4: begin ped_ew = 1'b1; @(negedge clk); ped_ew = 1'b0; end
         default: ;
      endcase
      tick = 1'b1;
      if (act == 3) begin
`ifdef PED_WALK_EN
         ped_ew = 1'b1;
`else
         car_ew = 1'b1;
`endif
      end
      @(negedge clk);
      tick   = 1'b0;
      car_ew = 1'b0;
      ped_ew = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   // Reset, release, and take the first tick into NS green (elapsed = 0).
   task automatic go_ns_g();
      tick = 1'b0; car_ns = 1'b0; car_ew = 1'b0; ped_ns = 1'b0; ped_ew = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      do_step(0);
   endtask

   task automatic test_reset();
      @(negedge clk);
      sb.push_back(exp_of(0, 1'b0, 1'b0));
      @(negedge clk);
      exp_v = sb.pop_front();
      n_run++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL reset_hold: got %s, want %s", fmt(obs), fmt(exp_v));
      end
      // A tick in the release cycle must not advance the all-red phase.
      rst = 1'b1;
      tick = 1'b1;
      sb.push_back(exp_of(0, 1'b0, 1'b0));
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
      @(negedge clk);
      exp_v = sb.pop_front();
      n_run++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL release_tick: got %s, want %s", fmt(obs), fmt(exp_v));
      end
      sb.push_back(exp_of(1, 1'b0, 1'b0));
      do_step(0);
      exp_v = sb.pop_front();
      n_run++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL first_tick: got %s, want %s", fmt(obs), fmt(exp_v));
      end
   endtask

   task automatic test_rest_on_green();
      go_ns_g();
      for (int i = 0; i < 41; i++) begin
         sb.push_back(exp_of((i == 40) ? 2 : 1, 1'b0, 1'b0));
         do_step((i == 40) ? 1 : 0);
         exp_v = sb.pop_front();
         n_run++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL rest_green step %0d: got %s, want %s", i, fmt(obs), fmt(exp_v));
         end
      end
   endtask

   task automatic test_gap_out();
      int acts[8] = '{0, 0, 1, 0, 0, 0, 0, 0};
      int phs[8]  = '{1, 1, 1, 1, 2, 2, 3, 4};
      go_ns_g();
      for (int i = 0; i < 8; i++) begin
         sb.push_back(exp_of(phs[i], 1'b0, 1'b0));
         do_step(acts[i]);
         exp_v = sb.pop_front();
         n_run++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL gap_out step %0d: got %s, want %s", i, fmt(obs), fmt(exp_v));
         end
      end
   endtask

   task automatic test_max_out();
      go_ns_g();
      car_ns = 1'b1;
      for (int i = 0; i < 12; i++) begin
         sb.push_back(exp_of((i == 11) ? 2 : 1, 1'b0, 1'b0));
         do_step((i == 0) ? 1 : 0);
         car_ns = 1'b1;
         exp_v = sb.pop_front();
         n_run++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL max_out tick %0d: got %s, want %s", i + 1, fmt(obs), fmt(exp_v));
         end
      end
      car_ns = 1'b0;
   endtask

   // An EW request on the EW green entry edge must survive into the next NS green.
   task automatic test_set_wins();
      int acts[21] = '{1, 0, 0, 0, 0, 0, 0, 3, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      int phs[21]  = '{1, 1, 1, 1, 2, 2, 3, 4, 4, 4, 4, 4, 5, 5, 0, 1, 1, 1, 1, 1, 2};
      go_ns_g();
      for (int i = 0; i < 21; i++) begin
         sb.push_back(exp_of(phs[i], 1'b0, 1'b0));
         do_step(acts[i]);
         exp_v = sb.pop_front();
         n_run++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL set_wins step %0d: got %s, want %s", i, fmt(obs), fmt(exp_v));
         end
      end
   endtask

   task automatic test_reset_mid_yellow();
      go_ns_g();
      for (int i = 0; i < 5; i++) begin
         sb.push_back(exp_of((i == 4) ? 2 : 1, 1'b0, 1'b0));
         do_step((i == 0) ? 1 : 0);
         exp_v = sb.pop_front();
         n_run++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL to_yellow step %0d: got %s, want %s", i, fmt(obs), fmt(exp_v));
         end
      end
      // Assert reset between clock edges; outputs must go all-red at once.
      #2;
      rst = 1'b0;
      sb.push_back(exp_of(0, 1'b0, 1'b0));
      #1;
      exp_v = sb.pop_front();
      n_run++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL reset_mid_yellow: got %s, want %s", fmt(obs), fmt(exp_v));
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

`ifdef PED_WALK_EN
   task automatic test_walk();
      int   acts[24] = '{4, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0,
                         0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
      int   phs[24]  = '{1, 1, 1, 1, 2, 2, 3, 4, 4, 4, 4, 4,
                         5, 5, 0, 1, 1, 1, 1, 1, 2, 2, 3, 4};
      logic wes[24]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0,
                         0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      go_ns_g();
      for (int i = 0; i < 24; i++) begin
         sb.push_back(exp_of(phs[i], 1'b0, wes[i]));
         do_step(acts[i]);
         exp_v = sb.pop_front();
         n_run++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL walk step %0d: got %s, want %s", i, fmt(obs), fmt(exp_v));
         end
      end
   endtask
`else
   task automatic test_ped_ignored();
      go_ns_g();
      ped_ns = 1'b1;
      for (int i = 0; i < 8; i++) begin
         sb.push_back(exp_of(1, 1'b0, 1'b0));
         do_step((i == 0) ? 4 : 0);
         exp_v = sb.pop_front();
         n_run++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL ped_ignored step %0d: got %s, want %s", i, fmt(obs), fmt(exp_v));
         end
      end
      ped_ns = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_rest_on_green();
      test_gap_out();
      test_max_out();
      test_set_wins();
      test_reset_mid_yellow();
`ifdef PED_WALK_EN
      test_walk();
`else
      test_ped_ignored();
`endif
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
